// File: rtl/gps_ack_scheduler_if.sv
// Signal bundle between the acquisition scheduler and its capture unit,
// correlator and result consumer. The scheduler side uses the master modport.
interface gps_ack_scheduler_if #(
    parameter int CORR_W = 12
);
    logic                     start;
    logic                     abort;
    logic [31:0]              sat_mask;
    logic [CORR_W:0]          threshold;
    logic                     cap_start;
    logic                     cap_done;
    logic                     corr_start;
    logic [5:0]               corr_sat;
    logic [9:0]               corr_code_phase;
    logic [15:0]              corr_doppler;
    logic                     corr_done;
    logic signed [CORR_W-1:0] corr_i;
    logic signed [CORR_W-1:0] corr_q;
    logic                     res_valid;
    logic                     res_ready;
    logic [5:0]               res_sat;
    logic [9:0]               res_code_phase;
    logic [15:0]              res_doppler;
    logic [CORR_W:0]          res_peak;
    logic                     res_detected;
    logic                     busy;
    logic                     search_complete;

    modport master (
        input  start, abort, sat_mask, threshold, cap_done,
               corr_done, corr_i, corr_q, res_ready,
        output cap_start, corr_start, corr_sat, corr_code_phase, corr_doppler,
               res_valid, res_sat, res_code_phase, res_doppler, res_peak,
               res_detected, busy, search_complete
    );

    modport slave (
        output start, abort, sat_mask, threshold, cap_done,
               corr_done, corr_i, corr_q, res_ready,
        input  cap_start, corr_start, corr_sat, corr_code_phase, corr_doppler,
               res_valid, res_sat, res_code_phase, res_doppler, res_peak,
               res_detected, busy, search_complete
    );
endinterface

// File: rtl/gps_ack_scheduler.sv
// GPS acquisition search sequencer: one capture, then a satellite / Doppler /
// code-phase sweep of correlations, reporting the peak per satellite.
module gps_ack_scheduler #(
    parameter int                 CODE_PHASES  = 1023,
    parameter int                 DOPPLER_NUM  = 3,
    parameter logic signed [15:0] DOPPLER_INIT = -16'sd13,
    parameter logic signed [15:0] DOPPLER_STEP = 16'sd13,
    parameter int                 CORR_W       = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    gps_ack_scheduler_if.master  bus
);
    localparam int MAG_W = CORR_W + 1;
    localparam int BIN_W = (DOPPLER_NUM > 1) ? $clog2(DOPPLER_NUM) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CAPTURE, S_CAP_WAIT, S_SEL, S_ISSUE, S_WAIT, S_ACCUM, S_REPORT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        mask_q, mask_d;
    logic [MAG_W-1:0]   thresh_q, thresh_d;
    logic [5:0]         sat_q, sat_d;
    logic [9:0]         phase_q, phase_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [15:0]        dop_q, dop_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [MAG_W-1:0]   peak_q, peak_d;
    logic [9:0]         res_phase_q, res_phase_d;
    logic [15:0]        res_dop_q, res_dop_d;
    logic [5:0]         res_sat_q, res_sat_d;
    logic               res_det_q, res_det_d;
    logic               cap_start_q, cap_start_d;
    logic               corr_start_q, corr_start_d;
    logic               res_valid_q, res_valid_d;
    logic               done_q, done_d;

    // Magnitude in one extra bit so |-2^(CORR_W-1)| and the 2^CORR_W sum fit.
    logic [MAG_W-1:0]   i_ext, q_ext, abs_i, abs_q, mag_in, peak_new;
    logic [4:0]         low_idx;
    logic               last_phase, last_bin, new_peak;

    assign i_ext  = {bus.corr_i[CORR_W-1], bus.corr_i};
    assign q_ext  = {bus.corr_q[CORR_W-1], bus.corr_q};
    assign abs_i  = i_ext[MAG_W-1] ? ((~i_ext) + MAG_W'(1)) : i_ext;
    assign abs_q  = q_ext[MAG_W-1] ? ((~q_ext) + MAG_W'(1)) : q_ext;
    assign mag_in = abs_i + abs_q;

    assign new_peak   = (mag_q > peak_q);
    assign peak_new   = new_peak ? mag_q : peak_q;
    assign last_phase = (phase_q == 10'(CODE_PHASES - 1));
    assign last_bin   = (bin_q == BIN_W'(DOPPLER_NUM - 1));

    always_comb begin
        low_idx = '0;
        for (int k = 31; k >= 0; k--) begin
            if (mask_q[k]) begin
                low_idx = 5'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        thresh_d     = thresh_q;
        sat_d        = sat_q;
        phase_d      = phase_q;
        bin_d        = bin_q;
        dop_d        = dop_q;
        mag_d        = mag_q;
        peak_d       = peak_q;
        res_phase_d  = res_phase_q;
        res_dop_d    = res_dop_q;
        res_sat_d    = res_sat_q;
        res_det_d    = res_det_q;
        cap_start_d  = 1'b0;
        corr_start_d = 1'b0;
        res_valid_d  = res_valid_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                res_valid_d = 1'b0;
                if (bus.start) begin
                    mask_d   = bus.sat_mask;
                    thresh_d = bus.threshold;
                    if (bus.sat_mask == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_CAPTURE;
                        cap_start_d = 1'b1;
                    end
                end
            end
            S_CAPTURE: state_d = S_CAP_WAIT;
            S_CAP_WAIT: begin
                if (bus.cap_done) begin
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (mask_q == 32'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    sat_d           = {1'b0, low_idx} + 6'd1;
                    mask_d[low_idx] = 1'b0;
                    peak_d          = '0;
                    phase_d         = '0;
                    bin_d           = '0;
                    dop_d           = DOPPLER_INIT;
                    res_phase_d     = '0;
                    res_dop_d       = DOPPLER_INIT;
                    state_d         = S_ISSUE;
                    corr_start_d    = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.corr_done) begin
                    mag_d   = mag_in;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                peak_d = peak_new;
                if (new_peak) begin
                    res_phase_d = phase_q;
                    res_dop_d   = dop_q;
                end
                // The sweep pointer is left on the final point so corr_* hold during REPORT.
                if (last_phase && last_bin) begin
                    state_d     = S_REPORT;
                    res_valid_d = 1'b1;
                    res_sat_d   = sat_q;
                    res_det_d   = (peak_new >= thresh_q);
                end else begin
                    state_d      = S_ISSUE;
                    corr_start_d = 1'b1;
                    if (last_phase) begin
                        phase_d = '0;
                        bin_d   = bin_q + BIN_W'(1);
                        dop_d   = dop_q + DOPPLER_STEP;
                    end else begin
                        phase_d = phase_q + 10'd1;
                    end
                end
            end
            S_REPORT: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_SEL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every same-cycle handshake and suppresses all pulses.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            res_valid_d  = 1'b0;
            cap_start_d  = 1'b0;
            corr_start_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            thresh_q     <= '0;
            sat_q        <= '0;
            phase_q      <= '0;
            bin_q        <= '0;
            dop_q        <= '0;
            mag_q        <= '0;
            peak_q       <= '0;
            res_phase_q  <= '0;
            res_dop_q    <= '0;
            res_sat_q    <= '0;
            res_det_q    <= 1'b0;
            cap_start_q  <= 1'b0;
            corr_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            thresh_q     <= thresh_d;
            sat_q        <= sat_d;
            phase_q      <= phase_d;
            bin_q        <= bin_d;
            dop_q        <= dop_d;
            mag_q        <= mag_d;
            peak_q       <= peak_d;
            res_phase_q  <= res_phase_d;
            res_dop_q    <= res_dop_d;
            res_sat_q    <= res_sat_d;
            res_det_q    <= res_det_d;
            cap_start_q  <= cap_start_d;
            corr_start_q <= corr_start_d;
            res_valid_q  <= res_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.cap_start       = cap_start_q;
    assign bus.corr_start      = corr_start_q;
    assign bus.corr_sat        = sat_q;
    assign bus.corr_code_phase = phase_q;
    assign bus.corr_doppler    = dop_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_sat         = res_sat_q;
    assign bus.res_code_phase  = res_phase_q;
    assign bus.res_doppler     = res_dop_q;
    assign bus.res_peak        = peak_q;
    assign bus.res_detected    = res_det_q;
    assign bus.search_complete = done_q;
    assign bus.busy            = (state_q != S_IDLE);
endmodule
